// File: rtl/tawas_pkg.sv
// Shared types and issue-rule helper for the Tawas load-return writeback queue.
// The optional same-cycle bypass is enabled with TAWAS_LD_WB_BYPASS_EN.
package tawas_pkg;

    localparam int TAWAS_NUM_THREADS = 16;
    localparam int TAWAS_NUM_REGS    = 8;

    typedef struct packed {
        logic [3:0]  thread;
        logic [2:0]  regn;
        logic [31:0] data;
    } tawas_ld_entry_t;

    // A load may use the store port only when it cannot collide with the pipeline writeback.
    function automatic logic tawas_can_issue(
        input logic                        pipe_wb_en,
        input logic [3:0]                  pipe_wb_thread,
        input logic                        pipe_store_busy,
        input logic [TAWAS_NUM_REGS-1:0]   pipe_reg_mask,
        input logic [3:0]                  thread,
        input logic [2:0]                  regn
    );
        logic port_free;
        port_free = !pipe_wb_en || ((pipe_wb_thread == thread) && !pipe_store_busy);
        return port_free && !pipe_reg_mask[regn];
    endfunction

endpackage

// File: rtl/tawas_ld_wb_chk.sv
// Checker: per-thread pending counters must never overflow or underflow.
module tawas_ld_wb_chk #(
    parameter int DEPTH = 4,
    parameter int NT    = 16,
    parameter int CW    = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic [NT-1:0]          i_inc,
    input logic [NT-1:0]          i_dec,
    input logic [NT-1:0][CW-1:0]  i_cnt
);

    // Flag any increment of a saturated counter or decrement of an empty one.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int t = 0; t < NT; t++) begin
                if (i_inc[t] && !i_dec[t]) begin
                    assert (i_cnt[t] != CW'(DEPTH)) else $error("ld count overflow thread %0d", t);
                end
                if (i_dec[t] && !i_inc[t]) begin
                    assert (i_cnt[t] != '0) else $error("ld count underflow thread %0d", t);
                end
            end
        end
    end

endmodule

// File: rtl/tawas_ld_wb_fifo.sv
// In-order synchronous FIFO of load-return entries; head is the oldest entry.
module tawas_ld_wb_fifo
    import tawas_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  tawas_ld_entry_t          i_din,
    output tawas_ld_entry_t          o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    tawas_ld_entry_t r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rptr];

    // Storage array, no reset needed since validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tawas_ld_wb.sv
// Load-return writeback queue: buffers bus read responses and slots them into free
// store-port cycles. Define TAWAS_LD_WB_BYPASS_EN for same-cycle issue when empty.
module tawas_ld_wb
    import tawas_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_rsp_valid,
    output logic                            o_rsp_ready,
    input  logic [3:0]                      i_rsp_thread,
    input  logic [2:0]                      i_rsp_reg,
    input  logic [31:0]                     i_rsp_data,
    input  logic                            i_pipe_wb_en,
    input  logic [3:0]                      i_pipe_wb_thread,
    input  logic                            i_pipe_store_busy,
    input  logic [7:0]                      i_pipe_reg_mask,
    output logic [3:0]                      o_wb_thread,
    output logic                            o_wb_store_en,
    output logic [2:0]                      o_wb_store_reg,
    output logic [31:0]                     o_wb_store_data,
    output logic [TAWAS_NUM_THREADS-1:0]    o_ld_pending,
    output logic [$clog2(DEPTH):0]          o_fifo_level
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int NT = TAWAS_NUM_THREADS;

    tawas_ld_entry_t         w_head;
    tawas_ld_entry_t         w_rsp;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_head_issue;
    logic                    w_byp;
    logic                    w_issue;
    logic [3:0]              w_src_thread;
    logic [NT-1:0]           w_inc;
    logic [NT-1:0]           w_dec;
    logic [NT-1:0][CW-1:0]   r_cnt;

    assign w_rsp       = '{thread: i_rsp_thread, regn: i_rsp_reg, data: i_rsp_data};
    assign o_rsp_ready = !w_full;
    assign w_accept    = i_rsp_valid && !w_full;
    assign w_push      = w_accept && !w_byp;
    assign w_issue     = w_head_issue || w_byp;

    tawas_ld_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_head_issue),
        .i_din   (w_rsp),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // Issue decision for the queue head and, when configured, the incoming response.
    always_comb begin
        w_head_issue = !w_empty && tawas_can_issue(i_pipe_wb_en, i_pipe_wb_thread,
                            i_pipe_store_busy, i_pipe_reg_mask, w_head.thread, w_head.regn);
`ifdef TAWAS_LD_WB_BYPASS_EN
        w_byp = w_empty && i_rsp_valid && tawas_can_issue(i_pipe_wb_en, i_pipe_wb_thread,
                            i_pipe_store_busy, i_pipe_reg_mask, i_rsp_thread, i_rsp_reg);
`else
        w_byp = 1'b0;
`endif
    end

    // Store-port drive; the thread bus is only taken over when the pipeline is idle.
    always_comb begin
        o_wb_store_en = w_issue;
        if (w_head_issue) begin
            w_src_thread    = w_head.thread;
            o_wb_store_reg  = w_head.regn;
            o_wb_store_data = w_head.data;
        end else if (w_byp) begin
            w_src_thread    = i_rsp_thread;
            o_wb_store_reg  = i_rsp_reg;
            o_wb_store_data = i_rsp_data;
        end else begin
            w_src_thread    = w_head.thread;
            o_wb_store_reg  = 3'd0;
            o_wb_store_data = 32'd0;
        end
        o_wb_thread = (w_issue && !i_pipe_wb_en) ? w_src_thread : i_pipe_wb_thread;
    end

    // Per-thread enqueue/dequeue strobes; bypassed responses never touch the counters.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int t = 0; t < NT; t++) begin
            w_inc[t] = w_push && (i_rsp_thread == 4'(t));
            w_dec[t] = w_head_issue && (w_head.thread == 4'(t));
        end
    end

    // Outstanding-load counters per thread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (w_inc[t] && !w_dec[t]) begin
                    r_cnt[t] <= r_cnt[t] + CW'(1);
                end else if (w_dec[t] && !w_inc[t]) begin
                    r_cnt[t] <= r_cnt[t] - CW'(1);
                end else begin
                    r_cnt[t] <= r_cnt[t];
                end
            end
        end
    end

    // Pending flags derived from the registered counters.
    always_comb begin
        o_ld_pending = '0;
        for (int t = 0; t < NT; t++) begin
            o_ld_pending[t] = (r_cnt[t] != '0);
        end
    end

    tawas_ld_wb_chk #(.DEPTH(DEPTH), .NT(NT), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_inc),
        .i_dec (w_dec),
        .i_cnt (r_cnt)
    );

endmodule

// File: tb/tb_tawas_ld_wb.sv
// Self-checking bench for tawas_ld_wb: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_tawas_ld_wb;

    localparam int DEPTH = 4;
`ifdef TAWAS_LD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [3:0]  rsp_thread = 4'd0;
    logic [2:0]  rsp_reg = 3'd0;
    logic [31:0] rsp_data = 32'd0;
    logic        pipe_wb_en = 1'b0;
    logic [3:0]  pipe_wb_thread = 4'd0;
    logic        pipe_store_busy = 1'b0;
    logic [7:0]  pipe_reg_mask = 8'd0;
    logic [3:0]  wb_thread;
    logic        wb_store_en;
    logic [2:0]  wb_store_reg;
    logic [31:0] wb_store_data;
    logic [15:0] ld_pending;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  th;
        logic [2:0]  rg;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    tawas_ld_wb #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_rsp_valid       (rsp_valid),
        .o_rsp_ready       (rsp_ready),
        .i_rsp_thread      (rsp_thread),
        .i_rsp_reg         (rsp_reg),
        .i_rsp_data        (rsp_data),
        .i_pipe_wb_en      (pipe_wb_en),
        .i_pipe_wb_thread  (pipe_wb_thread),
        .i_pipe_store_busy (pipe_store_busy),
        .i_pipe_reg_mask   (pipe_reg_mask),
        .o_wb_thread       (wb_thread),
        .o_wb_store_en     (wb_store_en),
        .o_wb_store_reg    (wb_store_reg),
        .o_wb_store_data   (wb_store_data),
        .o_ld_pending      (ld_pending),
        .o_fifo_level      (fifo_level)
    );

    // Collision rule for a load targeting (th, rg) against the current pipeline inputs.
    function automatic bit can_iss(input logic [3:0] th, input logic [2:0] rg);
        return (!pipe_wb_en || (pipe_wb_thread == th && !pipe_store_busy)) && !pipe_reg_mask[rg];
    endfunction

    // Reference model: a plain queue of outstanding loads.
    bit m_hi, m_acc, m_byp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            m_hi  = (mq.size() > 0) && can_iss(mq[0].th, mq[0].rg);
            m_acc = rsp_valid && (mq.size() < DEPTH);
            m_byp = BYP && (mq.size() == 0) && rsp_valid && can_iss(rsp_thread, rsp_reg);
            if (m_hi) void'(mq.pop_front());
            if (m_acc && !m_byp) mq.push_back('{rsp_thread, rsp_reg, rsp_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        rsp_valid = 1'b0; pipe_wb_en = 1'b0; pipe_store_busy = 1'b0; pipe_reg_mask = 8'h00;
    endtask

    task automatic drive_rsp(input logic [3:0] th, input logic [2:0] rg, input logic [31:0] d);
        rsp_valid = 1'b1; rsp_thread = th; rsp_reg = rg; rsp_data = d;
    endtask

    task automatic test_reset();
        set_idle();
        pipe_wb_thread = 4'd5;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rsp_ready); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (ld_pending !== 16'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", ld_pending); end
        n_cmp++; if (wb_store_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", wb_store_en); end
        n_cmp++; if (wb_thread !== 4'd5) begin n_fail++; $display("FAIL reset_wbthread: got %0d want 5", wb_thread); end
        n_cmp++; if (wb_store_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", wb_store_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_idle();
        drive_rsp(4'd3, 3'd5, 32'hDEADBEEF);
        #1;
        n_cmp++; if (wb_store_en !== BYP) begin n_fail++; $display("FAIL basic_en_N: got %b want %b", wb_store_en, BYP); end
        if (BYP) begin
            n_cmp++; if (wb_thread !== 4'd3 || wb_store_reg !== 3'd5 || wb_store_data !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL basic_byp_fields: got t=%0d r=%0d d=%h want 3/5/deadbeef", wb_thread, wb_store_reg, wb_store_data); end
        end
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (wb_store_en !== !BYP) begin n_fail++; $display("FAIL basic_en_N1: got %b want %b", wb_store_en, !BYP); end
        n_cmp++; if (ld_pending !== (BYP ? 16'h0 : 16'h0008)) begin n_fail++; $display("FAIL basic_pending_N1: got %h", ld_pending); end
        if (!BYP) begin
            n_cmp++; if (wb_thread !== 4'd3 || wb_store_reg !== 3'd5 || wb_store_data !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL basic_fields: got t=%0d r=%0d d=%h want 3/5/deadbeef", wb_thread, wb_store_reg, wb_store_data); end
        end
        tick();
        #1;
        n_cmp++; if (ld_pending !== 16'h0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL basic_drain: got pend=%h lvl=%0d want 0/0", ld_pending, fifo_level); end
        n_cmp++; if (wb_store_en !== 1'b0 || wb_store_reg !== 3'd0) begin
            n_fail++; $display("FAIL basic_idle: got en=%b reg=%0d want 0/0", wb_store_en, wb_store_reg); end
    endtask

    task automatic test_thread_conflict();
        set_idle();
        pipe_wb_en = 1'b1; pipe_wb_thread = 4'd7;
        drive_rsp(4'd2, 3'd1, 32'h1234_5678);
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (wb_store_en !== 1'b0 || wb_thread !== 4'd7) begin
                n_fail++; $display("FAIL conflict_block: got en=%b t=%0d want 0/7", wb_store_en, wb_thread); end
            tick();
        end
        pipe_wb_en = 1'b0;
        #1;
        n_cmp++; if (wb_store_en !== 1'b1 || wb_thread !== 4'd2 || wb_store_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL conflict_release: got en=%b t=%0d d=%h want 1/2/12345678", wb_store_en, wb_thread, wb_store_data); end
        tick();
    endtask

    task automatic test_reg_mask();
        set_idle();
        pipe_wb_en = 1'b1; pipe_wb_thread = 4'd4; pipe_reg_mask = 8'h02;
        drive_rsp(4'd4, 3'd1, 32'h0000_0044);
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (wb_store_en !== 1'b0 || fifo_level !== 3'd1) begin
            n_fail++; $display("FAIL mask_block: got en=%b lvl=%0d want 0/1", wb_store_en, fifo_level); end
        tick();
        pipe_reg_mask = 8'h01;
        #1;
        n_cmp++; if (wb_store_en !== 1'b1 || wb_thread !== 4'd4 || wb_store_reg !== 3'd1) begin
            n_fail++; $display("FAIL mask_issue: got en=%b t=%0d r=%0d want 1/4/1", wb_store_en, wb_thread, wb_store_reg); end
        tick();
        set_idle();
    endtask

    task automatic test_fill();
        set_idle();
        pipe_wb_en = 1'b1; pipe_wb_thread = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rsp(4'(i + 1), 3'(i), 32'hA000_0000 + 32'(i));
            #1;
            n_cmp++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, rsp_ready); end
            tick();
        end
        drive_rsp(4'd9, 3'd7, 32'hBAD0_BAD0);
        #1;
        n_cmp++; if (rsp_ready !== 1'b0 || fifo_level !== 3'(DEPTH)) begin
            n_fail++; $display("FAIL fill_full: got rdy=%b lvl=%0d want 0/%0d", rsp_ready, fifo_level, DEPTH); end
        tick();
        pipe_wb_en = 1'b0;
        #1;
        n_cmp++; if (rsp_ready !== 1'b0) begin n_fail++; $display("FAIL fill_no_passthru: got %b want 0", rsp_ready); end
        tick();
        rsp_valid = 1'b0;
        tick();
        // One rejected response held at the edge above, two heads already drained.
        for (int i = 2; i < DEPTH; i++) begin
            #1;
            n_cmp++; if (wb_store_en !== 1'b1 || wb_store_reg !== 3'(i) || wb_store_data !== 32'hA000_0000 + 32'(i)) begin
                n_fail++; $display("FAIL fill_order%0d: got en=%b r=%0d d=%h", i, wb_store_en, wb_store_reg, wb_store_data); end
            tick();
        end
        #1;
        n_cmp++; if (rsp_ready !== 1'b1 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL fill_drained: got rdy=%b lvl=%0d want 1/0", rsp_ready, fifo_level); end
    endtask

    task automatic test_same_thread();
        set_idle();
        pipe_wb_en = 1'b1; pipe_wb_thread = 4'd0;
        drive_rsp(4'd9, 3'd2, 32'h9000_0002);
        tick();
        pipe_wb_en = 1'b0;
        drive_rsp(4'd9, 3'd3, 32'h9000_0003);
        #1;
        n_cmp++; if (wb_store_en !== 1'b1 || wb_store_reg !== 3'd2 || ld_pending[9] !== 1'b1) begin
            n_fail++; $display("FAIL same_first: got en=%b r=%0d p9=%b want 1/2/1", wb_store_en, wb_store_reg, ld_pending[9]); end
        tick();
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (ld_pending !== 16'h0200 || fifo_level !== 3'd1 || wb_store_reg !== 3'd3) begin
            n_fail++; $display("FAIL same_second: got p=%h lvl=%0d r=%0d want 0200/1/3", ld_pending, fifo_level, wb_store_reg); end
        tick();
        #1;
        n_cmp++; if (ld_pending !== 16'h0) begin n_fail++; $display("FAIL same_clear: got %h want 0", ld_pending); end
    endtask

    task automatic test_reset_mid();
        set_idle();
        pipe_wb_en = 1'b1; pipe_wb_thread = 4'd0;
        for (int i = 0; i < 3; i++) begin
            drive_rsp(4'(i + 1), 3'(i), 32'hC000_0000 + 32'(i));
            tick();
        end
        rsp_valid = 1'b0;
        #1;
        n_cmp++; if (fifo_level !== 3'd3 || ld_pending !== 16'h000E) begin
            n_fail++; $display("FAIL rstmid_pre: got lvl=%0d p=%h want 3/000e", fifo_level, ld_pending); end
        #1;
        rst_n = 1'b0;
        pipe_wb_en = 1'b0;
        #1;
        n_cmp++; if (fifo_level !== 3'd0 || ld_pending !== 16'h0 || wb_store_en !== 1'b0 || rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_now: got lvl=%0d p=%h en=%b rdy=%b want 0/0/0/1", fifo_level, ld_pending, wb_store_en, rsp_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++; if (wb_store_en !== 1'b0 || fifo_level !== 3'd0) begin
                n_fail++; $display("FAIL rstmid_stale%0d: got en=%b lvl=%0d want 0/0", i, wb_store_en, fifo_level); end
        end
    endtask

    task automatic test_random();
        bit          e_hi, e_byp, e_en;
        logic [3:0]  e_src, e_wbt;
        logic [2:0]  e_reg;
        logic [31:0] e_data;
        logic [15:0] e_pend;
        for (int c = 0; c < 400; c++) begin
            rsp_valid       = ($urandom_range(0, 99) < 55);
            rsp_thread      = 4'($urandom_range(0, 3));
            rsp_reg         = 3'($urandom_range(0, 7));
            rsp_data        = $urandom;
            pipe_wb_en      = ($urandom_range(0, 99) < 50);
            pipe_wb_thread  = 4'($urandom_range(0, 3));
            pipe_store_busy = ($urandom_range(0, 99) < 30);
            pipe_reg_mask   = ($urandom_range(0, 99) < 65) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            #1;
            e_hi  = (mq.size() > 0) && can_iss(mq[0].th, mq[0].rg);
            e_byp = BYP && (mq.size() == 0) && rsp_valid && can_iss(rsp_thread, rsp_reg);
            e_en  = e_hi || e_byp;
            e_src = e_hi ? mq[0].th : rsp_thread;
            e_reg = e_hi ? mq[0].rg : (e_byp ? rsp_reg : 3'd0);
            e_data = e_hi ? mq[0].d : (e_byp ? rsp_data : 32'd0);
            e_wbt = (e_en && !pipe_wb_en) ? e_src : pipe_wb_thread;
            e_pend = 16'h0;
            foreach (mq[k]) e_pend[mq[k].th] = 1'b1;
            n_cmp++; if (wb_store_en !== e_en) begin n_fail++; $display("FAIL rnd_en c%0d: got %b want %b", c, wb_store_en, e_en); end
            n_cmp++; if (wb_thread !== e_wbt) begin n_fail++; $display("FAIL rnd_thread c%0d: got %0d want %0d", c, wb_thread, e_wbt); end
            n_cmp++; if (wb_store_reg !== e_reg || wb_store_data !== e_data) begin
                n_fail++; $display("FAIL rnd_payload c%0d: got %0d/%h want %0d/%h", c, wb_store_reg, wb_store_data, e_reg, e_data); end
            n_cmp++; if (rsp_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b", c, rsp_ready); end
            n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, mq.size()); end
            n_cmp++; if (ld_pending !== e_pend) begin n_fail++; $display("FAIL rnd_pending c%0d: got %h want %h", c, ld_pending, e_pend); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_thread_conflict();
        test_reg_mask();
        test_fill();
        test_same_thread();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tawas_ld_wb.md
# tawas_ld_wb

Load-return writeback queue for the Tawas core. Accepts bus read responses (thread, register, data) with variable latency. Buffers them in a small FIFO and drives them into the register file's store writeback port in cycles where that write cannot collide with the pipeline's own writeback. Publishes a per-thread pending flag so the thread scheduler does not start a thread whose register context still has load data in flight.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rsp_valid  in  1  bus read response valid.
- rsp_ready  out  1  response accepted when rsp_valid && rsp_ready at posedge.
- rsp_thread  in  4  destination thread.
- rsp_reg  in  3  destination register.
- rsp_data  in  32  load data.
- pipe_wb_en  in  1  pipeline performs a writeback this cycle.
- pipe_wb_thread  in  4  thread of the pipeline writeback.
- pipe_store_busy  in  1  pipeline is using the store writeback port this cycle.
- pipe_reg_mask  in  8  one-hot-or set of registers the pipeline writes this cycle (AU/pointer/store).
- wb_thread  out  4  merged writeback thread to the register file.
- wb_store_en  out  1  load writeback strobe.
- wb_store_reg  out  3  load writeback register.
- wb_store_data  out  32  load writeback data.
- ld_pending  out  16  bit t set while thread t has queued load data.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.

## Operation
- FIFO of {thread, reg, data} entries; in-order; head is the oldest entry.
- Accept: rsp_ready = !full. Accept occurs when rsp_valid && rsp_ready. There is no pass-through when full, even if the head issues in the same cycle.
- Issue condition, evaluated combinationally each cycle while the FIFO is non-empty:
  - (!pipe_wb_en) or (pipe_wb_thread == head.thread && !pipe_store_busy), and
  - pipe_reg_mask[head.reg] == 0.
- On issue: wb_store_en=1, reg/data taken from the head, and the head pops at the posedge.
- wb_thread = (issue && !pipe_wb_en) ? head.thread : pipe_wb_thread.
- When not issuing: wb_store_en=0, and wb_store_reg/wb_store_data = 0.
- Per-thread counters, width clog2(DEPTH+1):
  - +1 on accept for rsp_thread; −1 on issue for head.thread.
  - Accept and issue on the same thread in the same cycle leave the count unchanged.
  - ld_pending[t] = (count[t] != 0).
- Simultaneous accept and pop are both performed, so the level is unchanged.
- Counters never over- or underflow; a violation is an assertion failure.
- Head blocked indefinitely by the pipeline: no timeout. The head-of-line block is intentional to keep load order per register.

## Timing
- Response accepted at edge N is issuable in cycle N+1 at the earliest. It is written into the register file at N+2, because the register file registers its writeback inputs.
- ld_pending[t] rises the cycle after accept. It falls the cycle after the last issue for t.
- Throughput: one accept and one issue per cycle.
- Reset (async assert, sync deassert externally):
  - FIFO empty, level 0, all counters 0, ld_pending = 0.
  - wb_store_en = 0, rsp_ready = 1.
  - wb_thread follows pipe_wb_thread.
- Reset mid-operation discards all queued entries; no writeback is emitted for them.

## Configuration
- TAWAS_LD_WB_BYPASS_EN defined:
  - When the FIFO is empty, rsp_valid is high and the issue condition holds for rsp_thread/rsp_reg, the response is issued in the same cycle.
  - The bypassed response is not enqueued, and its counter is unchanged.
  - Zero added latency.
- Undefined: every response passes through the FIFO (minimum one-cycle residency).

## Structure
- tawas_pkg holds:
  - the typedef tawas_ld_entry_t {thread[3:0], reg[2:0], data[31:0]};
  - TAWAS_NUM_THREADS = 16;
  - TAWAS_NUM_REGS = 8.
- One sub-module, tawas_ld_wb_fifo: parameterized synchronous FIFO with push/pop/full/empty/level and head output.
- Issue logic and counters live in the top module.

## Test plan
- Idle pipeline, response {t=3, r=5, 0xDEADBEEF}: wb_store_en=1 with t=3/r=5/data in cycle N+1. ld_pending[3] is high for exactly one cycle. With BYPASS_EN, the issue happens in cycle N and ld_pending stays 0.
- pipe_wb_en=1 on thread 7 while the head targets thread 2: no issue. Issue follows the first cycle with pipe_wb_en=0, and wb_thread=2 in that cycle.
- Head {t=4, r=1} with pipe_wb_thread=4, pipe_store_busy=0, pipe_reg_mask=0x02: blocked. Next cycle with mask 0x01: issues with wb_thread=4.
- Fill DEPTH=4 while pipe_wb_en is held high on another thread: rsp_ready drops after 4 accepts and fifo_level=4. Release: 4 issues in order on consecutive cycles, then rsp_ready=1.
- Two responses for thread 9, with one accept and one issue in the same cycle: count[9] unchanged and ld_pending[9] stays high until the second issue.
- Assert rst_n low with 3 entries queued: level=0, ld_pending=0, wb_store_en=0 immediately. After release, no stale writeback appears.
